// File: rtl/kb_fifo_info.sv
// Keyboard scancode FIFO for the KB_INFO region: pop-on-read DATA, STATUS,
// pulse-style CTRL and a saturating drop counter, plus a not-empty interrupt.
module kb_fifo_info #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    parameter  int DROP_W = 16,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_addr,
    input  logic              cpu_re,
    output logic [31:0]       cpu_rddata,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_wrdata,
    input  logic              kb_we,
    input  logic [DATA_W-1:0] kb_wrdata,
    output logic              kb_irq,
    output logic [PTR_W:0]    kb_count
);

    // Strobes are single-cycle and carry no handshake: kb_we is an
    // unconditional push offer (dropped when full), cpu_re at DATA pops at
    // the same edge the CPU samples cpu_rddata, and cpu_we acts on that edge.
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_DROP   = 2'd3;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [1:0] reg_sel;
    logic       empty, full;
    logic       pop_req, flush, clr;
    logic       pop_ok, push_ok, drop;

    assign reg_sel = cpu_addr[3:2];
    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign pop_req = cpu_re && (reg_sel == ADDR_DATA);
    assign flush   = cpu_we && (reg_sel == ADDR_CTRL) && cpu_wrdata[0];
    assign clr     = cpu_we && (reg_sel == ADDR_CTRL) && cpu_wrdata[1];

    // A pop frees a slot in the same cycle, so push-while-full-with-pop succeeds.
    assign pop_ok  = pop_req && !empty && !flush;
    assign push_ok = kb_we && !flush && (!full || pop_ok);
    assign drop    = kb_we && !flush && full && !pop_ok;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = kb_wrdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + (PTR_W+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - (PTR_W+1)'(1);
            end
        end

        // Clear first so a same-cycle drop still registers afterwards.
        if (clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != {DROP_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_d + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; empty reads are masked to zero instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        cpu_rddata = '0;
        case (reg_sel)
            ADDR_DATA: begin
                if (!empty) begin
                    cpu_rddata[DATA_W-1:0] = mem_q[rd_ptr_q];
                end
            end
            ADDR_STATUS: begin
                cpu_rddata[0]            = empty;
                cpu_rddata[1]            = full;
                cpu_rddata[2]            = overflow_q;
                cpu_rddata[8 +: PTR_W+1] = count_q;
            end
            ADDR_DROP: begin
                cpu_rddata[DROP_W-1:0] = drop_cnt_q;
            end
            default: cpu_rddata = '0;
        endcase
    end

    assign kb_irq   = !empty;
    assign kb_count = count_q;

    logic unused_bits;
    assign unused_bits = ^{cpu_addr[31:4], cpu_addr[1:0], cpu_wrdata[31:2]};

endmodule

// File: doc/kb_fifo_info.md
Name: kb_fifo_info

Overview:
- Parametrised successor to the single-register keyboard info block in the memory map.
- Buffers keyboard scancode words in a DEPTH-entry FIFO instead of overwriting one register, so the CPU no longer loses keys between polls.
- Sits in the KB_INFO region. The memory map supplies the region-local address (prefix already masked off) and the region read/write strobes.
- Exposes data (pop-on-read), status, control and a saturating drop counter, plus a level interrupt.

Parameters:
- DATA_W, 32, width of one keyboard entry; cpu_rddata zero-extends it to 32 bits.
- DEPTH, 16, FIFO entries; power of 2, range 2..128.
- PTR_W, log2(DEPTH), pointer width; derived, not overridden.
- DROP_W, 16, drop counter width; 1..32.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- cpu_addr  in  32  region-local byte address; only bits [3:2] decoded, upper bits ignored.
- cpu_re  in  1  CPU read strobe for this region, one cycle per load.
- cpu_rddata  out  32  combinational read data for cpu_addr.
- cpu_we  in  1  CPU write strobe for this region.
- cpu_wrdata  in  32  CPU write data.
- kb_we  in  1  keyboard push strobe.
- kb_wrdata  in  DATA_W  keyboard entry to push.
- kb_irq  out  1  high while FIFO not empty.
- kb_count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:

Register map (word offset = cpu_addr[3:2]):
- 0 DATA:
  - Read returns the head entry zero-extended, or 0 when empty.
  - Read with cpu_re pops the head at the clock edge.
  - Writes are ignored.
- 1 STATUS (read-only):
  - bit0 empty, bit1 full, bit2 overflow (sticky).
  - bits[15:8] count, zero-extended; bits [7:3] and [31:16] read as 0.
- 2 CTRL:
  - Write-only; reads return 0. Write bits are pulses, not stored.
  - Write bit0=1 flushes: rd_ptr<=wr_ptr, count<=0.
  - Write bit1=1 clears overflow and drop_cnt.
  - Both bits may be set in one write; other bits ignored.
- 3 DROP_CNT (read-only): returns drop_cnt zero-extended; saturates at 2^DROP_W-1, no wrap.

Read path and pointers:
- cpu_rddata is purely combinational from cpu_addr and current state; no read latency, matching the existing region read mux.
- FIFO storage is a register array: write at wr_ptr, read at rd_ptr.
- Pointers are PTR_W bits and wrap naturally modulo DEPTH.
- count is tracked separately: empty = (count==0), full = (count==DEPTH).

Per-cycle events:
- push_req = kb_we; pop_req = cpu_re && addr==0.
- flush = cpu_we && addr==2 && cpu_wrdata[0]; clr = cpu_we && addr==2 && cpu_wrdata[1].

Priority and boundary rules, evaluated each cycle:
- rst: wr_ptr=rd_ptr=0, count=0, overflow=0, drop_cnt=0. Storage contents are don't-care. Reset overrides everything in that cycle.
- flush: pointers equalised, count=0. A same-cycle push and pop are both discarded; the discarded push does not count as a drop.
- Pop when empty: no effect; the read returns 0.
- Push when not full: the entry is written, wr_ptr++ and count++.
- Push when full with no same-cycle pop: the entry is dropped, overflow<=1, drop_cnt++ (saturating).
- Push and pop together when full: both succeed, count stays DEPTH, no drop.
- Push and pop together when empty: the pop is ignored and the push succeeds; count becomes 1.
- Push and pop together in any other state: both succeed, count unchanged.
- clr with a drop in the same cycle: the drop wins, so overflow=1 and drop_cnt=1 (cleared, then incremented).
- clr and flush together: both take effect.

Reset values and timing:
- Outputs after reset: kb_irq=0, kb_count=0, cpu_rddata=0 for addr 0/2/3, STATUS reads 0x00000001.
- kb_irq and kb_count are registered-state derived and update the cycle after the causing edge.
- A pushed entry is visible at DATA from the next cycle; there is no write-through on the same cycle.

Test Plan:
- Reset, then read STATUS and DATA -> 0x00000001 and 0x00000000; kb_irq=0.
- Push 0x1C, 0x32, 0x21 on three cycles; three DATA reads with cpu_re -> 0x1C, 0x32, 0x21 in order; STATUS then 0x00000001; kb_irq falls the cycle after the last pop.
- DEPTH=16: push 20 distinct values with no pops -> STATUS=0x00001006 (count 16, full, overflow); DROP_CNT=4; popping all 16 yields values 1..16. Then write CTRL=0x2 -> overflow 0, DROP_CNT=0.
- Fill to full, then push 0xAA and pop in the same cycle -> the popped value is the oldest entry, count stays 16, DROP_CNT unchanged, 0xAA appears last. Then, at empty, push and pop in the same cycle -> count becomes 1 and the head is the pushed value.
- Push 5 entries, then write CTRL=0x1 in the same cycle as a push and a DATA pop -> count=0, empty, DROP_CNT unchanged. The next push of 0x55 reads back 0x55, confirming pointer wrap is coherent.
- Drive rst for one cycle mid-stream with count=7 and a simultaneous push -> count=0, overflow=0, STATUS=0x00000001 the next cycle.
